mini_encoder: RTL and testbench



---
 rtl/mini_encoder.sv | 131 +++++++++++++
 tb/tb_mini_encoder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mini_encoder.sv
// RV32I ALU instruction encoder (OP / OP-IMM) feeding a small word FIFO that
// streams encoded words out with a sequential instruction-memory address.
module mini_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_isimm,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_func3,
  input  logic              in_funcqual,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_pulse,
  output logic [7:0]        err_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  logic [31:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_addr;
  logic              r_alive;
  logic              r_err_pulse;
  logic [7:0]        r_err_count;

  logic        w_full;
  logic        w_empty;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic        w_reject;
  logic        w_is_shift;
  logic        w_legal;
  logic [31:0] w_word;

  always_comb begin
    w_is_shift    = (in_func3 == 3'b001) || (in_func3 == 3'b101);
    w_word        = '0;
    w_legal       = 1'b0;
    w_word[11:7]  = in_rd;
    w_word[14:12] = in_func3;
    w_word[19:15] = in_rs1;
    if (in_isimm) begin
      w_word[6:0] = OPC_OP_IMM;
      if (w_is_shift) begin
        w_word[24:20] = in_imm[4:0];
        w_word[31:25] = {1'b0, in_funcqual, 5'b0};
        w_legal       = (in_imm[31:5] == 27'd0) && (!in_funcqual || (in_func3 == 3'b101));
      end else begin
        // Immediate must fit the 12-bit signed field: bits 31..11 all copies of the sign.
        w_word[31:20] = in_imm[11:0];
        w_legal       = ((&in_imm[31:11]) || !(|in_imm[31:11])) && !in_funcqual;
      end
    end else begin
      w_word[6:0]   = OPC_OP;
      w_word[24:20] = in_rs2;
      w_word[31:25] = {1'b0, in_funcqual, 5'b0};
      w_legal       = !in_funcqual || (in_func3 == 3'b000) || (in_func3 == 3'b101);
    end
  end

  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign in_ready  = r_alive && !w_full && !clear;
  assign w_accept  = in_valid && in_ready;
  assign w_push    = w_accept && w_legal;
  assign w_reject  = w_accept && !w_legal;
  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;
  // Gate the read so an empty FIFO always presents zero rather than stale data.
  assign out_instr = w_empty ? 32'd0 : r_mem[r_rptr];
  assign out_addr  = r_addr;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_word;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_addr      <= BASE;
      r_alive     <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= 8'd0;
    end else begin
      r_alive     <= 1'b1;
      r_err_pulse <= w_reject;
      if (clear) begin
        r_wptr      <= '0;
        r_rptr      <= '0;
        r_count     <= '0;
        r_addr      <= BASE;
        r_err_count <= 8'd0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop) begin
          r_rptr <= r_rptr + 1'b1;
          r_addr <= r_addr + 1'b1;
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + 1'b1;
        end else if (!w_push && w_pop) begin
          r_count <= r_count - 1'b1;
        end
        if (w_reject && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mini_encoder.sv
// Directed self-checking bench for mini_encoder; a second instance with a
// 2-bit address starting at 3 shares the inputs to exercise address wrap.
module tb_mini_encoder;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_isimm = 1'b0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [2:0]  in_func3 = '0;
  logic        in_funcqual = 1'b0;
  logic [31:0] in_imm = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, err_pulse;
  logic [31:0] out_instr;
  logic [9:0]  out_addr;
  logic [7:0]  err_count;

  logic        w2_in_ready, w2_out_valid, w2_err_pulse;
  logic [31:0] w2_out_instr;
  logic [1:0]  w2_out_addr;
  logic [7:0]  w2_err_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mini_encoder dut (
    .clk(clk), .resetn(resetn), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_isimm(in_isimm),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_func3(in_func3),
    .in_funcqual(in_funcqual), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .err_pulse(err_pulse), .err_count(err_count)
  );

  mini_encoder #(.FIFO_DEPTH(4), .ADDR_W(2), .BASE_ADDR(3)) dut_w (
    .clk(clk), .resetn(resetn), .clear(clear),
    .in_valid(in_valid), .in_ready(w2_in_ready), .in_isimm(in_isimm),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_func3(in_func3),
    .in_funcqual(in_funcqual), .in_imm(in_imm),
    .out_valid(w2_out_valid), .out_ready(out_ready), .out_instr(w2_out_instr),
    .out_addr(w2_out_addr), .err_pulse(w2_err_pulse), .err_count(w2_err_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic isimm, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3, input logic fq,
                            input logic [31:0] imm);
    in_isimm = isimm; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_func3 = f3; in_funcqual = fq; in_imm = imm;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_checks++; if (out_instr !== 32'd0) begin n_fail++; $display("FAIL reset_out_instr: got %h want 0", out_instr); end
    n_checks++; if (out_addr !== 10'd0) begin n_fail++; $display("FAIL reset_out_addr: got %0d want 0", out_addr); end
    n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_err_pulse: got %0b want 0", err_pulse); end
    n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
    n_checks++; if (w2_out_addr !== 2'd3) begin n_fail++; $display("FAIL reset_wrap_addr: got %0d want 3", w2_out_addr); end
    resetn = 1'b1;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %0b want 1", in_ready); end
    $display("reset: released");
  endtask

  task automatic test_legal();
    logic        v_isimm [3] = '{1'b1, 1'b0, 1'b0};
    logic [4:0]  v_rd    [3] = '{5'd1, 5'd3, 5'd3};
    logic [4:0]  v_rs1   [3] = '{5'd0, 5'd1, 5'd1};
    logic [4:0]  v_rs2   [3] = '{5'd0, 5'd2, 5'd2};
    logic        v_fq    [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] v_imm   [3] = '{32'd5, 32'd0, 32'd0};
    logic [31:0] exp_w   [3] = '{32'h00500093, 32'h002081B3, 32'h402081B3};
    logic [1:0]  exp_w2  [3] = '{2'd3, 2'd0, 2'd1};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_fields(v_isimm[i], v_rd[i], v_rs1[i], v_rs2[i], 3'b000, v_fq[i], v_imm[i]);
      in_valid = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL legal_in_ready[%0d]: got %0b want 1", i, in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL legal_no_bypass[%0d]: got %0b want 0", i, out_valid); end
      tick();
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL legal_valid[%0d]: got %0b want 1", i, out_valid); end
      n_checks++; if (out_instr !== exp_w[i]) begin n_fail++; $display("FAIL legal_instr[%0d]: got %h want %h", i, out_instr, exp_w[i]); end
      n_checks++; if (out_addr !== 10'(i)) begin n_fail++; $display("FAIL legal_addr[%0d]: got %0d want %0d", i, out_addr, i); end
      n_checks++; if (w2_out_instr !== exp_w[i]) begin n_fail++; $display("FAIL wrap_instr[%0d]: got %h want %h", i, w2_out_instr, exp_w[i]); end
      n_checks++; if (w2_out_addr !== exp_w2[i]) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, w2_out_addr, exp_w2[i]); end
      $display("legal: word %h addr %0d wrap_addr %0d", out_instr, out_addr, w2_out_addr);
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL legal_drained[%0d]: got %0b want 0", i, out_valid); end
    end
  endtask

  task automatic test_imm_edges();
    logic [4:0]  v_rd  [2] = '{5'd1, 5'd5};
    logic [4:0]  v_rs1 [2] = '{5'd0, 5'd6};
    logic [2:0]  v_f3  [2] = '{3'b000, 3'b101};
    logic        v_fq  [2] = '{1'b0, 1'b1};
    logic [31:0] v_imm [2] = '{32'hFFFFFFFF, 32'd3};
    logic [31:0] exp_w [2] = '{32'hFFF00093, 32'h40335293};
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_fields(1'b1, v_rd[i], v_rs1[i], 5'd0, v_f3[i], v_fq[i], v_imm[i]);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL imm_valid[%0d]: got %0b want 1", i, out_valid); end
      n_checks++; if (out_instr !== exp_w[i]) begin n_fail++; $display("FAIL imm_instr[%0d]: got %h want %h", i, out_instr, exp_w[i]); end
      n_checks++; if (out_addr !== 10'(3 + i)) begin n_fail++; $display("FAIL imm_addr[%0d]: got %0d want %0d", i, out_addr, 3 + i); end
      $display("imm: word %h addr %0d", out_instr, out_addr);
      tick();
    end
  endtask

  task automatic test_illegal();
    logic        v_isimm [3] = '{1'b1, 1'b1, 1'b0};
    logic [4:0]  v_rd    [3] = '{5'd1, 5'd1, 5'd3};
    logic [4:0]  v_rs1   [3] = '{5'd0, 5'd0, 5'd1};
    logic [4:0]  v_rs2   [3] = '{5'd0, 5'd0, 5'd2};
    logic [2:0]  v_f3    [3] = '{3'b000, 3'b001, 3'b001};
    logic        v_fq    [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] v_imm   [3] = '{32'd2048, 32'd32, 32'd0};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_fields(v_isimm[i], v_rd[i], v_rs1[i], v_rs2[i], v_f3[i], v_fq[i], v_imm[i]);
      in_valid = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_in_ready[%0d]: got %0b want 1", i, in_ready); end
      tick();
      in_valid = 1'b0;
      n_checks++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL illegal_pulse[%0d]: got %0b want 1", i, err_pulse); end
      n_checks++; if (err_count !== 8'(i + 1)) begin n_fail++; $display("FAIL illegal_count[%0d]: got %0d want %0d", i, err_count, i + 1); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL illegal_no_word[%0d]: got %0b want 0", i, out_valid); end
      $display("illegal: set %0d rejected, err_count %0d", i, err_count);
      tick();
      n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL illegal_pulse_end[%0d]: got %0b want 0", i, err_pulse); end
      n_checks++; if (out_addr !== 10'd5) begin n_fail++; $display("FAIL illegal_addr[%0d]: got %0d want 5", i, out_addr); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_w [5] = '{32'h00100093, 32'h00200093, 32'h00300093, 32'h00400093, 32'h00500093};
    logic accepted;
    logic fifth_taken = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_fields(1'b1, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'(i + 1));
      in_valid = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %0b want 1", i, in_ready); end
      tick();
      n_checks++; if (out_instr !== exp_w[0]) begin n_fail++; $display("FAIL bp_hold_instr[%0d]: got %h want %h", i, out_instr, exp_w[0]); end
      n_checks++; if (out_addr !== 10'd5) begin n_fail++; $display("FAIL bp_hold_addr[%0d]: got %0d want 5", i, out_addr); end
      $display("backpressure: pushed word %0d", i);
    end
    set_fields(1'b1, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5);
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: got %0b want 0", in_ready); end
    tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall: got %0b want 0", in_ready); end
    n_checks++; if (out_instr !== exp_w[0]) begin n_fail++; $display("FAIL bp_stall_instr: got %h want %h", out_instr, exp_w[0]); end
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d]: got %0b want 1", j, out_valid); end
      n_checks++; if (out_instr !== exp_w[j]) begin n_fail++; $display("FAIL drain_instr[%0d]: got %h want %h", j, out_instr, exp_w[j]); end
      n_checks++; if (out_addr !== 10'(5 + j)) begin n_fail++; $display("FAIL drain_addr[%0d]: got %0d want %0d", j, out_addr, 5 + j); end
      n_checks++; if (in_ready !== (j != 0)) begin n_fail++; $display("FAIL drain_in_ready[%0d]: got %0b want %0b", j, in_ready, (j != 0)); end
      $display("drain: word %h addr %0d", out_instr, out_addr);
      accepted = in_valid && in_ready;
      tick();
      if (accepted) begin
        in_valid = 1'b0;
        fifth_taken = 1'b1;
      end
    end
    n_checks++; if (fifth_taken !== 1'b1) begin n_fail++; $display("FAIL bp_fifth_accept: got %0b want 1", fifth_taken); end
    n_checks++; if (out_instr !== exp_w[4]) begin n_fail++; $display("FAIL bp_fifth_instr: got %h want %h", out_instr, exp_w[4]); end
    n_checks++; if (out_addr !== 10'd9) begin n_fail++; $display("FAIL bp_fifth_addr: got %0d want 9", out_addr); end
    $display("drain: word %h addr %0d", out_instr, out_addr);
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic        v_isimm [3] = '{1'b1, 1'b0, 1'b1};
    logic [4:0]  v_rd    [3] = '{5'd1, 5'd3, 5'd5};
    logic [4:0]  v_rs1   [3] = '{5'd0, 5'd1, 5'd6};
    logic [4:0]  v_rs2   [3] = '{5'd0, 5'd2, 5'd0};
    logic [2:0]  v_f3    [3] = '{3'b000, 3'b000, 3'b101};
    logic        v_fq    [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] v_imm   [3] = '{32'd5, 32'd0, 32'd3};
    logic [31:0] exp_w   [3] = '{32'h00500093, 32'h002081B3, 32'h40335293};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_fields(v_isimm[i], v_rd[i], v_rs1[i], v_rs2[i], v_f3[i], v_fq[i], v_imm[i]);
      in_valid = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %0b want 1", i, in_ready); end
      if (i > 0) begin
        n_checks++; if (out_instr !== exp_w[i-1]) begin n_fail++; $display("FAIL b2b_instr[%0d]: got %h want %h", i, out_instr, exp_w[i-1]); end
        n_checks++; if (out_addr !== 10'(10 + i - 1)) begin n_fail++; $display("FAIL b2b_addr[%0d]: got %0d want %0d", i, out_addr, 10 + i - 1); end
        $display("b2b: word %h addr %0d", out_instr, out_addr);
      end
      tick();
    end
    in_valid = 1'b0;
    n_checks++; if (out_instr !== exp_w[2]) begin n_fail++; $display("FAIL b2b_last_instr: got %h want %h", out_instr, exp_w[2]); end
    n_checks++; if (out_addr !== 10'd12) begin n_fail++; $display("FAIL b2b_last_addr: got %0d want 12", out_addr); end
    $display("b2b: word %h addr %0d", out_instr, out_addr);
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %0b want 0", out_valid); end
  endtask

  task automatic test_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_fields(i == 0, 5'd1, 5'd0, 5'd2, 3'b000, 1'b0, 32'd5);
      in_valid = 1'b1;
      tick();
    end
    set_fields(1'b0, 5'd3, 5'd1, 5'd2, 3'b000, 1'b1, 32'd0);
    clear = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL clear_in_ready: got %0b want 0", in_ready); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clear_pre_valid: got %0b want 1", out_valid); end
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clear_valid: got %0b want 0", out_valid); end
    n_checks++; if (out_addr !== 10'd0) begin n_fail++; $display("FAIL clear_addr: got %0d want 0", out_addr); end
    n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL clear_err_count: got %0d want 0", err_count); end
    n_checks++; if (out_instr !== 32'd0) begin n_fail++; $display("FAIL clear_instr: got %h want 0", out_instr); end
    n_checks++; if (w2_out_addr !== 2'd3) begin n_fail++; $display("FAIL clear_wrap_addr: got %0d want 3", w2_out_addr); end
    $display("clear: fifo flushed, addr %0d", out_addr);
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clear_no_store: got %0b want 0", out_valid); end
  endtask

  task automatic test_err_saturate();
    set_fields(1'b1, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2048);
    in_valid = 1'b1;
    repeat (256) @(posedge clk);
    #1;
    n_checks++; if (err_count !== 8'd255) begin n_fail++; $display("FAIL sat_count: got %0d want 255", err_count); end
    n_checks++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL sat_pulse: got %0b want 1", err_pulse); end
    in_valid = 1'b0;
    tick();
    n_checks++; if (err_count !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got %0d want 255", err_count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sat_no_word: got %0b want 0", out_valid); end
    $display("saturate: err_count %0d", err_count);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_fields(1'b1, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd7);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    n_checks++; if (out_addr !== 10'd0) begin n_fail++; $display("FAIL mid_pre_addr: got %0d want 0", out_addr); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %0b want 1", out_valid); end
    resetn = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %0b want 0", out_valid); end
    n_checks++; if (out_instr !== 32'd0) begin n_fail++; $display("FAIL mid_instr: got %h want 0", out_instr); end
    n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL mid_err_count: got %0d want 0", err_count); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_in_ready: got %0b want 0", in_ready); end
    n_checks++; if (w2_out_addr !== 2'd3) begin n_fail++; $display("FAIL mid_wrap_addr: got %0d want 3", w2_out_addr); end
    $display("reset_mid: outputs cleared asynchronously");
    tick();
    resetn = 1'b1;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_release_ready: got %0b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_release_valid: got %0b want 0", out_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_legal();
    test_imm_edges();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_clear();
    test_err_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
